// File: rtl/gate_alu_pkg.sv
// Shared definitions for the gate_alu_pipe bitwise unit: op encodings,
// FSM state encodings and the bitwise evaluation function used by both the
// direct path and the accumulate path.
package gate_alu_pkg;

  // Widest operand gate_op can evaluate; callers zero-extend and truncate.
  // Every op is bitwise, so truncating the result is exact.
  localparam int GATE_MAXW = 64;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

  // x is operand A on the direct path and the accumulator in ACC state.
  function automatic logic [GATE_MAXW-1:0] gate_op(
    input logic [2:0]           op,
    input logic [GATE_MAXW-1:0] x,
    input logic [GATE_MAXW-1:0] b
  );
    case (op)
      OP_AND:  gate_op = x & b;
      OP_OR:   gate_op = x | b;
      OP_XOR:  gate_op = x ^ b;
      OP_NAND: gate_op = ~(x & b);
      OP_NOR:  gate_op = ~(x | b);
      OP_XNOR: gate_op = ~(x ^ b);
      OP_NOT:  gate_op = ~x;
      default: gate_op = x;           // OP_PASS
    endcase
  endfunction

endpackage

// File: rtl/gate_alu_fifo2.sv
// Two-entry in-order FIFO with registered in_rdy_o / out_vld_o.
// Ports: clk, rst (async, active-high); push_i/push_dat_i write side;
//   pop_i read side (effective only while out_vld_o); head_dat_o is the head
//   register, forced to zero when empty; in_rdy_o = not full, out_vld_o = not empty.
module gate_alu_fifo2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] push_dat_i,
  input  logic          pop_i,
  output logic          in_rdy_o,
  output logic          out_vld_o,
  output logic [DW-1:0] head_dat_o
);

  logic [1:0]    count_q, count_d;
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic          in_rdy_q, out_vld_q;
  logic          pop;

  assign pop = pop_i && out_vld_q;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (count_q)
      2'd0: begin
        if (push_i) begin
          head_d  = push_dat_i;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push_i && pop) begin
          head_d = push_dat_i;
        end else if (push_i) begin
          tail_d  = push_dat_i;
          count_d = 2'd2;
        end else if (pop) begin
          // Clear the head so the output reads zero while empty.
          head_d  = '0;
          count_d = 2'd0;
        end
      end
      2'd2: begin
        // Push cannot occur here: in_rdy_o is low while full.
        if (pop) begin
          head_d  = tail_q;
          tail_d  = '0;
          count_d = 2'd1;
        end
      end
      default: begin
        count_d = 2'd0;
        head_d  = '0;
        tail_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= 2'd0;
      head_q    <= '0;
      tail_q    <= '0;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      // Flags derived from next count keep them registered yet current.
      in_rdy_q  <= (count_d != 2'd2);
      out_vld_q <= (count_d != 2'd0);
    end
  end

  assign in_rdy_o   = in_rdy_q;
  assign out_vld_o  = out_vld_q;
  assign head_dat_o = head_q;

endmodule

// File: rtl/gate_alu_pipe.sv
// Pipelined WIDTH-bit bitwise unit with 8 ops, an accumulate mode
// (acc = acc OP b over a beat sequence) and a 2-entry output buffer.
// Ports: clk, rst (async, active-high); in_valid/in_ready/op/acc_mode/
//   acc_last/a/b input beat; out_valid/out_ready/y result. Optional
//   GATE_ALU_REDUCE_EN adds red_and/red_or/red_xor stored alongside y.
module gate_alu_pipe
  import gate_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  input  logic             acc_last,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y
`ifdef GATE_ALU_REDUCE_EN
  ,
  output logic             red_and,
  output logic             red_or,
  output logic             red_xor
`endif
);

`ifdef GATE_ALU_REDUCE_EN
  localparam int DW = WIDTH + 3;
`else
  localparam int DW = WIDTH;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] res;
  logic             accept;
  logic             push;
  logic [DW-1:0]    push_dat;
  logic [DW-1:0]    head_dat;
  logic             fifo_in_rdy;
  logic             fifo_out_vld;

  assign accept = in_valid && fifo_in_rdy;

  // In ACC the accumulator replaces operand A, so NOT/PASS act on acc.
  assign x   = (state_q == ST_ACC) ? acc_q : a;
  assign res = WIDTH'(gate_op(op, GATE_MAXW'(x), GATE_MAXW'(b)));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    push    = 1'b0;
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (acc_mode && !acc_last) begin
            acc_d   = res;
            state_d = ST_ACC;
          end else begin
            push = 1'b1;
          end
        end
        ST_ACC: begin
          if (acc_last) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            acc_d = res;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

`ifdef GATE_ALU_REDUCE_EN
  assign push_dat = {^res, |res, &res, res};
`else
  assign push_dat = res;
`endif

  gate_alu_fifo2 #(
    .DW (DW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (out_ready),
    .in_rdy_o   (fifo_in_rdy),
    .out_vld_o  (fifo_out_vld),
    .head_dat_o (head_dat)
  );

  assign in_ready  = fifo_in_rdy;
  assign out_valid = fifo_out_vld;
  assign y         = head_dat[WIDTH-1:0];

`ifdef GATE_ALU_REDUCE_EN
  // Empty buffer holds zero, so these read 0 whenever out_valid is low.
  assign red_and = head_dat[WIDTH];
  assign red_or  = head_dat[WIDTH+1];
  assign red_xor = head_dat[WIDTH+2];
`endif

endmodule

// File: tb/tb_gate_alu_pipe.sv
module tb_gate_alu_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic       acc_mode;
  logic       acc_last;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
`ifdef GATE_ALU_REDUCE_EN
  logic       red_and;
  logic       red_or;
  logic       red_xor;
`endif

  int total = 0;
  int bad   = 0;
  int npop  = 0;

  // Reference model: list of results waiting in the buffer, and sequence state.
  logic [7:0] mq[$];
  bit         m_in_seq = 1'b0;
  logic [7:0] m_acc    = 8'h00;

  gate_alu_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .acc_mode  (acc_mode),
    .acc_last  (acc_last),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
`ifdef GATE_ALU_REDUCE_EN
    ,
    .red_and   (red_and),
    .red_or    (red_or),
    .red_xor   (red_xor)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] bb);
    case (o)
      3'd0: return x & bb;
      3'd1: return x | bb;
      3'd2: return x ^ bb;
      3'd3: return ~(x & bb);
      3'd4: return ~(x | bb);
      3'd5: return ~(x ^ bb);
      3'd6: return ~x;
      default: return x;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: check outputs against the model, apply this cycle's
  // handshakes to the model, then advance to 1 time unit past the edge.
  task automatic cycle(output bit accepted);
    bit         pop;
    bit         push;
    logic [7:0] r;
    push = 1'b0;
    r    = 8'h00;
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
    if (mq.size() != 0) chk("y", 32'(y), 32'(mq[0]));
    else                chk("y_empty", 32'(y), 32'(0));
    pop      = out_ready && (mq.size() != 0);
    accepted = in_valid && (mq.size() < 2);
    if (accepted) begin
      if (!m_in_seq) begin
        r = ref_op(op, a, b);
        if (acc_mode && !acc_last) begin
          m_acc    = r;
          m_in_seq = 1'b1;
        end else begin
          push = 1'b1;
        end
      end else begin
        r = ref_op(op, m_acc, b);
        if (acc_last) begin
          push     = 1'b1;
          m_in_seq = 1'b0;
        end else begin
          m_acc = r;
        end
      end
    end
    if (pop) begin
      void'(mq.pop_front());
      npop++;
    end
    if (push) mq.push_back(r);
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb,
                      input logic mode, input logic last);
    bit acc;
    int n;
    op = o; a = aa; b = bb; acc_mode = mode; acc_last = last;
    in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      cycle(acc);
      n++;
    end
    if (!acc) chk("beat_timeout", 32'(1), 32'(0));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (mq.size() != 0 && n < 10) begin
      cycle(acc);
      n++;
    end
    if (mq.size() != 0) chk("drain_timeout", 32'(1), 32'(0));
    cycle(acc);
  endtask

  initial begin
    logic [7:0] tbl[8];
    bit         acc;
    int         p0;
    tbl = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h0F, 8'hF0};

    rst = 1'b1; in_valid = 1'b0; op = 3'd0; acc_mode = 1'b0; acc_last = 1'b0;
    a = 8'h00; b = 8'h00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_y", 32'(y), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Truth sweep: each result appears one clock after its accept.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      beat(3'(i), 8'hF0, 8'hCC, 1'b0, 1'b0);
      chk("sweep", 32'(y), 32'(tbl[i]));
    end
    drain();

    // Accumulate sequence yields exactly one result, then back to direct mode.
    p0 = npop;
    beat(3'd0, 8'hFF, 8'h0F, 1'b1, 1'b0);
    chk("acc_nopush", 32'(out_valid), 32'(0));
    beat(3'd1, 8'h00, 8'h30, 1'b0, 1'b0);
    chk("acc_nopush2", 32'(out_valid), 32'(0));
    beat(3'd2, 8'h00, 8'h01, 1'b0, 1'b1);
    chk("acc_result", 32'(y), 32'(8'h3E));
    beat(3'd1, 8'h00, 8'h55, 1'b0, 1'b0);
    chk("acc_idle_after", 32'(y), 32'(8'h55));
    drain();
    chk("acc_count", 32'(npop - p0), 32'(2));

    // Backpressure: third beat stalls until the consumer drains.
    p0 = npop;
    out_ready = 1'b0;
    beat(3'd7, 8'h11, 8'h00, 1'b0, 1'b0);
    beat(3'd7, 8'h22, 8'h00, 1'b0, 1'b0);
    op = 3'd7; a = 8'h33; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(acc);
      chk("bp_stall", 32'(acc), 32'(0));
    end
    chk("bp_in_ready_low", 32'(in_ready), 32'(0));
    out_ready = 1'b1;
    cycle(acc);
    chk("bp_no_accept_while_full", 32'(acc), 32'(0));
    cycle(acc);
    chk("bp_accept", 32'(acc), 32'(1));
    in_valid = 1'b0;
    drain();
    chk("bp_count", 32'(npop - p0), 32'(3));

    // Simultaneous push/pop at one entry: steady one result per clock.
    p0 = npop;
    out_ready = 1'b1;
    op = 3'd7; b = 8'h00; acc_mode = 1'b0; acc_last = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = 8'(8'hA0 + i);
      cycle(acc);
      chk("pp_accept", 32'(acc), 32'(1));
    end
    chk("pp_out_valid", 32'(out_valid), 32'(1));
    chk("pp_in_ready", 32'(in_ready), 32'(1));
    in_valid = 1'b0;
    drain();
    chk("pp_count", 32'(npop - p0), 32'(10));

`ifdef GATE_ALU_REDUCE_EN
    beat(3'd2, 8'h0F, 8'h0E, 1'b0, 1'b0);
    chk("red_y", 32'(y), 32'(8'h01));
    chk("red_and", 32'(red_and), 32'(0));
    chk("red_or", 32'(red_or), 32'(1));
    chk("red_xor", 32'(red_xor), 32'(1));
    drain();
    chk("red_empty_or", 32'(red_or), 32'(0));
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      op        = 3'($urandom_range(0, 7));
      a         = 8'($urandom);
      b         = 8'($urandom);
      acc_mode  = ($urandom_range(0, 2) == 0);
      acc_last  = ($urandom_range(0, 1) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle(acc);
    end
    drain();

    // Reset in the middle of an accumulate sequence discards it.
    beat(3'd0, 8'hFF, 8'h0F, 1'b1, 1'b0);
    beat(3'd1, 8'h00, 8'h30, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    chk("rst_mid_out_valid", 32'(out_valid), 32'(0));
    chk("rst_mid_y", 32'(y), 32'(0));
    chk("rst_mid_in_ready", 32'(in_ready), 32'(1));
    mq.delete();
    m_in_seq = 1'b0;
    m_acc    = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    beat(3'd0, 8'hFF, 8'h81, 1'b0, 1'b0);
    chk("rst_mid_next", 32'(y), 32'(8'h81));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
